// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter for the shared 8:1 mux: one grantee at a time, tenure bounded by MAX_HOLD,
// registered one-hot grant and registered mux select.
module mux8_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 4,
  parameter int unsigned HOLD_W   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic [2:0] sel,
  output logic       gnt_valid,
  output logic       busy
);

  localparam int unsigned N     = 8;
  localparam int unsigned IDX_W = 3;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t             state;
  logic [IDX_W-1:0]   last;
  logic [HOLD_W-1:0]  hold_cnt;
  logic               found;
  logic [IDX_W-1:0]   win;
  logic [IDX_W-1:0]   cand;
  logic               tenure_end;

  // Search last+1 .. last+8 (mod 8); the final candidate is last itself.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int i = 1; i <= int'(N); i++) begin
      cand = last + IDX_W'(i);
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  assign tenure_end = !req[last] || (hold_cnt == HOLD_W'(MAX_HOLD));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      gnt       <= '0;
      sel       <= '0;
      gnt_valid <= 1'b0;
      busy      <= 1'b0;
      last      <= IDX_W'(N - 1);
      hold_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (en && found) begin
            state     <= GRANT;
            gnt       <= N'(1) << win;
            sel       <= win;
            last      <= win;
            hold_cnt  <= HOLD_W'(1);
            gnt_valid <= 1'b1;
            busy      <= 1'b1;
          end else begin
            gnt       <= '0;
            gnt_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        GRANT: begin
          if (!en) begin
            state     <= IDLE;
            gnt       <= '0;
            gnt_valid <= 1'b0;
            busy      <= 1'b0;
            hold_cnt  <= '0;
          end else if (tenure_end) begin
            // Hand over in the same edge so there is no dead cycle between tenures.
            if (found) begin
              gnt      <= N'(1) << win;
              sel      <= win;
              last     <= win;
              hold_cnt <= HOLD_W'(1);
            end else begin
              state     <= IDLE;
              gnt       <= '0;
              gnt_valid <= 1'b0;
              busy      <= 1'b0;
              hold_cnt  <= '0;
            end
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end
        default: begin
          state     <= IDLE;
          gnt       <= '0;
          gnt_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Directed bench for mux8_rr_arbiter (MAX_HOLD=4) with hand-computed expected grants.
module tb_mux8_rr_arbiter;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] sel;
  logic       gnt_valid;
  logic       busy;

  int n_assert = 0;
  int n_fail   = 0;

  mux8_rr_arbiter #(.MAX_HOLD(4), .HOLD_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .req       (req),
    .gnt       (gnt),
    .sel       (sel),
    .gnt_valid (gnt_valid),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [7:0] eg, input logic [2:0] es);
    chk({tag, ".gnt"}, gnt, eg);
    chk({tag, ".sel"}, 8'(sel), 8'(es));
    chk({tag, ".valid"}, 8'(gnt_valid), 8'(|eg));
    chk({tag, ".busy"}, 8'(busy), 8'(|eg));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    req   = 8'h00;
    #3;
    chk_out("por", 8'h00, 3'd0);
    #4;
    rst_n = 1'b1;

    // Mid-tenure async reset, then restart from index 0
    en = 1'b1; req = 8'h10;
    tick(); chk_out("pre_rst", 8'h10, 3'd4);
    #1 rst_n = 1'b0;
    #1 chk_out("async_rst", 8'h00, 3'd0);
    rst_n = 1'b1;
    req = 8'h01;
    tick(); chk_out("post_rst", 8'h01, 3'd0);
    req = 8'h00;
    tick(); chk_out("release_idle", 8'h00, 3'd0);

    // Solo holder keeps the grant across tenure boundaries
    req = 8'h08;
    for (int c = 0; c < 9; c++) begin
      tick(); chk_out("solo", 8'h08, 3'd3);
    end

    // Full contention: 0..7 then 0, four cycles each
    do_reset();
    req = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      for (int c = 0; c < 4; c++) begin
        if (k < 8 || c == 0) begin
          tick(); chk_out("rr_full", 8'h01 << (k % 8), 3'(k % 8));
        end
      end
    end

    // Wrap 6 -> 7 -> 0
    do_reset();
    req = 8'h40;
    tick(); chk_out("wrap_last6", 8'h40, 3'd6);
    req = 8'h81;
    for (int c = 0; c < 4; c++) begin
      tick(); chk_out("wrap_to7", 8'h80, 3'd7);
    end
    tick(); chk_out("wrap_to0", 8'h01, 3'd0);

    // Early release hands over in the same edge; new grantee gets a full tenure
    do_reset();
    req = 8'h04;
    tick(); chk_out("early_a", 8'h04, 3'd2);
    tick(); chk_out("early_b", 8'h04, 3'd2);
    req = 8'h20;
    tick(); chk_out("early_switch", 8'h20, 3'd5);
    req = 8'h24;
    for (int c = 0; c < 3; c++) begin
      tick(); chk_out("early_hold", 8'h20, 3'd5);
    end
    tick(); chk_out("early_next", 8'h04, 3'd2);

    // Enable gating
    do_reset();
    req = 8'h04;
    tick(); chk_out("en_a", 8'h04, 3'd2);
    tick(); chk_out("en_b", 8'h04, 3'd2);
    en = 1'b0; req = 8'hFF;
    tick(); chk_out("en_off", 8'h00, 3'd2);
    tick(); chk_out("en_off_hold", 8'h00, 3'd2);
    en = 1'b1;
    tick(); chk_out("en_on", 8'h08, 3'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
